// File: rtl/mnist_input_binarizer.sv
// mnist_input_binarizer: thresholds an 8-bit pixel stream and packs each frame into one bit vector
module mnist_input_binarizer #(
  parameter int NUM_PIXELS = 784,
  parameter int PIXEL_W = 8,
  parameter int THRESHOLD = 128,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [PIXEL_W-1:0]    s_data,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [NUM_PIXELS-1:0] m_data,
  output logic                  err_len,
  output logic [CNT_W-1:0]      frame_cnt
);
  localparam int pw = $clog2(NUM_PIXELS);
  localparam logic [pw-1:0] last_idx = pw'(NUM_PIXELS - 1);
  typedef enum logic [1:0] {FILL, HOLD, DRAIN} state_t;
  state_t state;
  logic [pw-1:0] pix_cnt;
  logic drain_pend;
  logic [NUM_PIXELS-1:0] frame_buf;
  logic acc;
  logic bit_in;
  logic at_end;
  assign acc = s_valid && s_ready;
  assign bit_in = s_data >= PIXEL_W'(THRESHOLD);
  assign at_end = pix_cnt == last_idx;
  assign m_data = frame_buf;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      s_ready <= 1'b0;
      m_valid <= 1'b0;
      frame_buf <= '0;
      err_len <= 1'b0;
      frame_cnt <= '0;
      pix_cnt <= '0;
      drain_pend <= 1'b0;
    end else begin
      err_len <= 1'b0;
      case (state)
        FILL: begin
          s_ready <= 1'b1;
          if (acc) begin
            frame_buf[pix_cnt] <= bit_in;
            pix_cnt <= (at_end || s_last) ? '0 : pix_cnt + 1'b1;
            err_len <= at_end != s_last;
            if (at_end) begin
              state <= HOLD;
              s_ready <= 1'b0;
              m_valid <= 1'b1;
              drain_pend <= !s_last;
            end
          end
        end
        HOLD: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            frame_cnt <= frame_cnt + 1'b1;
            drain_pend <= 1'b0;
            state <= drain_pend ? DRAIN : FILL;
            s_ready <= 1'b1;
          end
        end
        DRAIN: begin
          if (acc && s_last) state <= FILL;
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_mnist_input_binarizer.sv
// tb_mnist_input_binarizer: randomized frame-level checks against a behavioural binarizer model
module tb_mnist_input_binarizer;
  localparam int n = 784;
  localparam int cw = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_valid = 1'b0;
  logic s_ready;
  logic [7:0] s_data = '0;
  logic s_last = 1'b0;
  logic m_valid;
  logic m_ready = 1'b0;
  logic [n-1:0] m_data;
  logic err_len;
  logic [cw-1:0] frame_cnt;
  int n_chk = 0;
  int n_err = 0;
  int err_seen = 0;
  int exp_err = 0;
  int exp_cnt = 0;
  int pix [n];
  mnist_input_binarizer #(.NUM_PIXELS(n), .PIXEL_W(8), .THRESHOLD(128), .CNT_W(cw)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .err_len(err_len), .frame_cnt(frame_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (err_len === 1'b1) err_seen <= err_seen + 1;
  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  task automatic check(input string tag, input logic [n-1:0] got, input logic [n-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [n-1:0] model_frame();
    logic [n-1:0] v;
    for (int i = 0; i < n; i++) v[i] = pix[i] >= 128;
    return v;
  endfunction
  task automatic put(input int d, input logic l);
    int w = 0;
    if ($urandom_range(0, 7) == 0) begin
      s_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    s_valid = 1'b1;
    s_data = 8'(d);
    s_last = l;
    while (s_ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w == 100) check("ready_timeout", 0, 1);
    @(negedge clk);
    s_valid = 1'b0;
    s_last = 1'($urandom_range(0, 1));
    s_data = 8'($urandom);
  endtask
  task automatic stream(input int cnt, input int last_at);
    for (int i = 0; i < cnt; i++) put(pix[i], i == last_at);
  endtask
  task automatic emit(input int stall);
    logic [n-1:0] snap;
    bit bad = 0;
    check("m_valid_rise", m_valid, 1);
    check("s_ready_hold", s_ready, 0);
    check("m_data", m_data, model_frame());
    snap = m_data;
    s_valid = 1'b1;
    repeat (stall) begin
      @(negedge clk);
      if (m_data !== snap || s_ready !== 1'b0 || m_valid !== 1'b1) bad = 1;
    end
    check("hold_stable", bad, 0);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    s_valid = 1'b0;
    exp_cnt = (exp_cnt + 1) % (1 << cw);
    check("m_valid_fall", m_valid, 0);
    check("s_ready_back", s_ready, 1);
    check("frame_cnt", frame_cnt, exp_cnt);
    check("err_count", err_seen, exp_err);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    @(negedge clk);
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_err_len", err_len, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    rst = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
    check("ready_after_rst", s_ready, 1);
    check("err_after_rst", err_seen, exp_err);
  endtask
  task automatic rand_frame();
    for (int i = 0; i < n; i++) pix[i] = $urandom_range(0, 255);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    do_reset();
    for (int i = 0; i < n; i++) pix[i] = (i * 37) % 256;
    stream(n, n - 1);
    emit(0);
    rand_frame();
    stream(n, n - 1);
    emit(50);
    rand_frame();
    stream(101, 100);
    repeat (3) @(negedge clk);
    exp_err++;
    check("early_no_valid", m_valid, 0);
    check("early_err", err_seen, exp_err);
    rand_frame();
    stream(n, n - 1);
    emit($urandom_range(0, 5));
    rand_frame();
    stream(n, -1);
    exp_err++;
    emit($urandom_range(0, 5));
    for (int i = 0; i < 5; i++) put($urandom_range(0, 255), i == 4);
    repeat (2) @(negedge clk);
    check("drain_no_valid", m_valid, 0);
    rand_frame();
    stream(n, n - 1);
    emit(0);
    for (int i = 0; i < n; i++) pix[i] = (i % 2) ? 128 : 127;
    stream(n, n - 1);
    emit(2);
    for (int i = 0; i < n; i++) pix[i] = 0;
    stream(n, n - 1);
    emit(0);
    for (int i = 0; i < n; i++) pix[i] = 255;
    stream(n, n - 1);
    emit(1);
    rand_frame();
    stream(n, n - 1);
    emit($urandom_range(0, 20));
    rand_frame();
    stream(400, -1);
    do_reset();
    rand_frame();
    stream(n, n - 1);
    emit(0);
    rand_frame();
    stream(n, n - 1);
    do_reset();
    rand_frame();
    stream(n, n - 1);
    emit($urandom_range(0, 10));
    check("final_err", err_seen, exp_err);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
